regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_if.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile.sv | 101 ++++++++++
 tb/tb_regfile.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, indices and types for the register file and its busy-bit
// scoreboards.
package regfile_pkg;
    localparam int SIZE_DATA   = 24;
    localparam int HBIT_DATA   = SIZE_DATA - 1;
    localparam int SIZE_GP     = 16;
    localparam int HBIT_TGT_GP = 3;
    localparam int SIZE_SR     = 16;
    localparam int HBIT_TGT_SR = 3;
    localparam int SIZE_FLAG   = 4;
    localparam int HBIT_FLAG   = SIZE_FLAG - 1;

    // SR slots with special handling: PC is substituted by execute, FL holds flags.
    localparam logic [HBIT_TGT_SR:0] INDEX_FL = 4'd14;
    localparam logic [HBIT_TGT_SR:0] INDEX_PC = 4'd15;

    typedef logic [HBIT_DATA:0]   data_t;
    typedef logic [HBIT_TGT_GP:0] gp_idx_t;
    typedef logic [HBIT_TGT_SR:0] sr_idx_t;
    typedef logic [HBIT_FLAG:0]   flags_t;
endpackage

// File: rtl/regfile_if.sv
// Read, writeback, flag and issue signals of the register file.
interface regfile_if;
    import regfile_pkg::*;

    gp_idx_t iw_gp_read_addr1;
    gp_idx_t iw_gp_read_addr2;
    data_t   ow_gp_read_data1;
    data_t   ow_gp_read_data2;
    sr_idx_t iw_sr_read_addr1;
    sr_idx_t iw_sr_read_addr2;
    data_t   ow_sr_read_data1;
    data_t   ow_sr_read_data2;
    logic    iw_gp_write_en;
    gp_idx_t iw_gp_write_addr;
    data_t   iw_gp_write_data;
    logic    iw_sr_write_en;
    sr_idx_t iw_sr_write_addr;
    data_t   iw_sr_write_data;
    logic    iw_fl_we;
    flags_t  iw_fl;
    logic    iw_issue_gp_en;
    gp_idx_t iw_issue_gp;
    logic    iw_issue_sr_en;
    sr_idx_t iw_issue_sr;
    logic    ow_stall;
    flags_t  ow_fl;

    modport master (
        output iw_gp_read_addr1, iw_gp_read_addr2, iw_sr_read_addr1, iw_sr_read_addr2,
        output iw_gp_write_en, iw_gp_write_addr, iw_gp_write_data,
        output iw_sr_write_en, iw_sr_write_addr, iw_sr_write_data,
        output iw_fl_we, iw_fl, iw_issue_gp_en, iw_issue_gp, iw_issue_sr_en, iw_issue_sr,
        input  ow_gp_read_data1, ow_gp_read_data2, ow_sr_read_data1, ow_sr_read_data2,
        input  ow_stall, ow_fl
    );

    modport slave (
        input  iw_gp_read_addr1, iw_gp_read_addr2, iw_sr_read_addr1, iw_sr_read_addr2,
        input  iw_gp_write_en, iw_gp_write_addr, iw_gp_write_data,
        input  iw_sr_write_en, iw_sr_write_addr, iw_sr_write_data,
        input  iw_fl_we, iw_fl, iw_issue_gp_en, iw_issue_gp, iw_issue_sr_en, iw_issue_sr,
        output ow_gp_read_data1, ow_gp_read_data2, ow_sr_read_data1, ow_sr_read_data2,
        output ow_stall, ow_fl
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on
// writeback, and a stall flag for either read port hitting a busy entry.
module scoreboard #(
    parameter int               DEPTH      = 16,
    parameter int               HBIT_IDX   = 3,
    parameter logic [DEPTH-1:0] NEVER_BUSY = '0
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_set_en,
    input  logic [HBIT_IDX:0] iw_set_idx,
    input  logic              iw_clr_en,
    input  logic [HBIT_IDX:0] iw_clr_idx,
    input  logic [HBIT_IDX:0] iw_rd_idx1,
    input  logic [HBIT_IDX:0] iw_rd_idx2,
    output logic              ow_stall
);
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_set_mask;
    logic [DEPTH-1:0] w_clr_mask;
    logic [DEPTH-1:0] w_busy_next;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (iw_set_en) w_set_mask[iw_set_idx] = 1'b1;
        if (iw_clr_en) w_clr_mask[iw_clr_idx] = 1'b1;
    end

    // Set dominates clear: a same-cycle issue means a newer producer is in flight.
    assign w_busy_next = (w_set_mask & ~NEVER_BUSY) | (r_busy & ~w_clr_mask);

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) r_busy <= '0;
        else           r_busy <= w_busy_next;
    end

    // A writeback in flight this cycle resolves the hazard via bypass.
    assign ow_stall = (r_busy[iw_rd_idx1] && !w_clr_mask[iw_rd_idx1]) ||
                      (r_busy[iw_rd_idx2] && !w_clr_mask[iw_rd_idx2]);
endmodule

// File: rtl/regfile.sv
// GP/SR register file with write-to-read bypass, flag sub-field in SR FL,
// and busy-bit hazard detection for source operands.
module regfile
    import regfile_pkg::*;
(
    input logic       iw_clk,
    input logic       iw_rst_n,
    regfile_if.slave  rf
);
    data_t   r_gp [SIZE_GP];
    data_t   r_sr [SIZE_SR];
    data_t   w_fl_entry;
    gp_idx_t w_gp_raddr [2];
    sr_idx_t w_sr_raddr [2];
    data_t   w_gp_rdata [2];
    data_t   w_sr_rdata [2];
    logic    w_gp_stall;
    logic    w_sr_stall;

    // Next value of the FL entry; a full SR write outranks a flag-only update.
    always_comb begin
        w_fl_entry = r_sr[INDEX_FL];
        if (rf.iw_sr_write_en && rf.iw_sr_write_addr == INDEX_FL)
            w_fl_entry = rf.iw_sr_write_data;
        else if (rf.iw_fl_we)
            w_fl_entry = {r_sr[INDEX_FL][HBIT_DATA:SIZE_FLAG], rf.iw_fl};
    end

    assign w_gp_raddr[0] = rf.iw_gp_read_addr1;
    assign w_gp_raddr[1] = rf.iw_gp_read_addr2;
    assign w_sr_raddr[0] = rf.iw_sr_read_addr1;
    assign w_sr_raddr[1] = rf.iw_sr_read_addr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign w_gp_rdata[gi] =
                (rf.iw_gp_write_en && rf.iw_gp_write_addr == w_gp_raddr[gi]) ?
                rf.iw_gp_write_data : r_gp[w_gp_raddr[gi]];
            assign w_sr_rdata[gi] =
                (w_sr_raddr[gi] == INDEX_PC) ? '0 :
                (w_sr_raddr[gi] == INDEX_FL) ? w_fl_entry :
                (rf.iw_sr_write_en && rf.iw_sr_write_addr == w_sr_raddr[gi]) ?
                rf.iw_sr_write_data : r_sr[w_sr_raddr[gi]];
        end
    endgenerate

    assign rf.ow_gp_read_data1 = w_gp_rdata[0];
    assign rf.ow_gp_read_data2 = w_gp_rdata[1];
    assign rf.ow_sr_read_data1 = w_sr_rdata[0];
    assign rf.ow_sr_read_data2 = w_sr_rdata[1];
    assign rf.ow_fl            = w_fl_entry[HBIT_FLAG:0];

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < SIZE_GP; i++) r_gp[i] <= '0;
            for (int i = 0; i < SIZE_SR; i++) r_sr[i] <= '0;
        end else begin
            if (rf.iw_gp_write_en)
                r_gp[rf.iw_gp_write_addr] <= rf.iw_gp_write_data;
            if (rf.iw_sr_write_en && rf.iw_sr_write_addr != INDEX_FL &&
                rf.iw_sr_write_addr != INDEX_PC)
                r_sr[rf.iw_sr_write_addr] <= rf.iw_sr_write_data;
            r_sr[INDEX_FL] <= w_fl_entry;
        end
    end

    scoreboard #(
        .DEPTH      (SIZE_GP),
        .HBIT_IDX   (HBIT_TGT_GP),
        .NEVER_BUSY ('0)
    ) u_sb_gp (
        .iw_clk     (iw_clk),
        .iw_rst_n   (iw_rst_n),
        .iw_set_en  (rf.iw_issue_gp_en),
        .iw_set_idx (rf.iw_issue_gp),
        .iw_clr_en  (rf.iw_gp_write_en),
        .iw_clr_idx (rf.iw_gp_write_addr),
        .iw_rd_idx1 (rf.iw_gp_read_addr1),
        .iw_rd_idx2 (rf.iw_gp_read_addr2),
        .ow_stall   (w_gp_stall)
    );

    scoreboard #(
        .DEPTH      (SIZE_SR),
        .HBIT_IDX   (HBIT_TGT_SR),
        .NEVER_BUSY ({{(SIZE_SR-1){1'b0}}, 1'b1} << INDEX_PC)
    ) u_sb_sr (
        .iw_clk     (iw_clk),
        .iw_rst_n   (iw_rst_n),
        .iw_set_en  (rf.iw_issue_sr_en),
        .iw_set_idx (rf.iw_issue_sr),
        .iw_clr_en  (rf.iw_sr_write_en),
        .iw_clr_idx (rf.iw_sr_write_addr),
        .iw_rd_idx1 (rf.iw_sr_read_addr1),
        .iw_rd_idx2 (rf.iw_sr_read_addr2),
        .ow_stall   (w_sr_stall)
    );

    assign rf.ow_stall = w_gp_stall | w_sr_stall;
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expectations queued as stimulus is driven,
// then popped and checked on the falling edge of the same cycle.
module tb_regfile;
    import regfile_pkg::*;

    localparam int SEL_GP1 = 0, SEL_GP2 = 1, SEL_SR1 = 2, SEL_SR2 = 3, SEL_STALL = 4, SEL_FL = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    exp_t   sb_q[$];
    int     total = 0;
    int     bad = 0;
    data_t  gp_model [SIZE_GP];

    regfile_if rf_if ();

    regfile dut (
        .iw_clk   (clk),
        .iw_rst_n (rst_n),
        .rf       (rf_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(int sel);
        case (sel)
            SEL_GP1:   return {8'h0, rf_if.ow_gp_read_data1};
            SEL_GP2:   return {8'h0, rf_if.ow_gp_read_data2};
            SEL_SR1:   return {8'h0, rf_if.ow_sr_read_data1};
            SEL_SR2:   return {8'h0, rf_if.ow_sr_read_data2};
            SEL_STALL: return {31'h0, rf_if.ow_stall};
            default:   return {28'h0, rf_if.ow_fl};
        endcase
    endfunction

    task automatic idle();
        rf_if.iw_gp_read_addr1 = '0;
        rf_if.iw_gp_read_addr2 = '0;
        rf_if.iw_sr_read_addr1 = '0;
        rf_if.iw_sr_read_addr2 = '0;
        rf_if.iw_gp_write_en   = 1'b0;
        rf_if.iw_gp_write_addr = '0;
        rf_if.iw_gp_write_data = '0;
        rf_if.iw_sr_write_en   = 1'b0;
        rf_if.iw_sr_write_addr = '0;
        rf_if.iw_sr_write_data = '0;
        rf_if.iw_fl_we         = 1'b0;
        rf_if.iw_fl            = '0;
        rf_if.iw_issue_gp_en   = 1'b0;
        rf_if.iw_issue_gp      = '0;
        rf_if.iw_issue_sr_en   = 1'b0;
        rf_if.iw_issue_sr      = '0;
    endtask

    task automatic expect_val(string tag, int sel, logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = val;
        sb_q.push_back(e);
    endtask

    // Check queued expectations mid-cycle, then step to just after the next edge.
    task automatic settle();
        exp_t e;
        logic [31:0] o;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs(e.sel);
            total++;
            assert (o === e.exp) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gp_write(gp_idx_t a, data_t d);
        rf_if.iw_gp_write_en   = 1'b1;
        rf_if.iw_gp_write_addr = a;
        rf_if.iw_gp_write_data = d;
    endtask

    task automatic sr_write(sr_idx_t a, data_t d);
        rf_if.iw_sr_write_en   = 1'b1;
        rf_if.iw_sr_write_addr = a;
        rf_if.iw_sr_write_data = d;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        rf_if.iw_gp_read_addr1 = 4'd3;
        rf_if.iw_sr_read_addr1 = 4'd2;
        expect_val("rst_gp", SEL_GP1, 32'h0);
        expect_val("rst_sr", SEL_SR1, 32'h0);
        expect_val("rst_stall", SEL_STALL, 32'h0);
        expect_val("rst_fl", SEL_FL, 32'h0);
        settle();

        // Same-cycle bypass, then stored value
        idle();
        gp_write(4'd3, 24'h00ABCD);
        rf_if.iw_gp_read_addr1 = 4'd3;
        expect_val("gp3_bypass", SEL_GP1, 32'h00ABCD);
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd3;
        rf_if.iw_gp_read_addr2 = 4'd3;
        expect_val("gp3_stored1", SEL_GP1, 32'h00ABCD);
        expect_val("gp3_stored2", SEL_GP2, 32'h00ABCD);
        settle();

        // Bypass is per read port
        idle();
        gp_write(4'd4, 24'h111111);
        rf_if.iw_gp_read_addr1 = 4'd3;
        rf_if.iw_gp_read_addr2 = 4'd4;
        expect_val("port1_nobyp", SEL_GP1, 32'h00ABCD);
        expect_val("port2_byp", SEL_GP2, 32'h111111);
        settle();

        // Fill all GP entries from a model, then read back in pairs
        for (int i = 0; i < SIZE_GP; i++) begin
            idle();
            gp_model[i] = data_t'(i * 32'h010203) ^ 24'h5A5A5A;
            gp_write(gp_idx_t'(i), gp_model[i]);
            settle();
        end
        for (int i = 0; i < SIZE_GP; i++) begin
            idle();
            rf_if.iw_gp_read_addr1 = gp_idx_t'(i);
            rf_if.iw_gp_read_addr2 = gp_idx_t'(SIZE_GP - 1 - i);
            expect_val($sformatf("gp_fill_a%0d", i), SEL_GP1, {8'h0, gp_model[i]});
            expect_val($sformatf("gp_fill_b%0d", i), SEL_GP2, {8'h0, gp_model[SIZE_GP - 1 - i]});
            settle();
        end

        // PC writes ignored, PC reads zero
        idle();
        sr_write(INDEX_PC, 24'h123456);
        rf_if.iw_sr_read_addr1 = INDEX_PC;
        expect_val("pc_same_cycle", SEL_SR1, 32'h0);
        settle();
        idle();
        rf_if.iw_sr_read_addr2 = INDEX_PC;
        expect_val("pc_after", SEL_SR2, 32'h0);
        settle();

        // Ordinary SR write/read
        idle();
        sr_write(4'd2, 24'h654321);
        rf_if.iw_sr_read_addr2 = 4'd2;
        expect_val("sr2_bypass", SEL_SR2, 32'h654321);
        settle();
        idle();
        rf_if.iw_sr_read_addr1 = 4'd2;
        expect_val("sr2_stored", SEL_SR1, 32'h654321);
        settle();

        // Flag field inside SR FL
        idle();
        sr_write(INDEX_FL, 24'hABCDE5);
        rf_if.iw_sr_read_addr1 = INDEX_FL;
        expect_val("fl_full_wr", SEL_FL, 32'h5);
        expect_val("fl_full_sr", SEL_SR1, 32'hABCDE5);
        settle();
        idle();
        rf_if.iw_fl_we = 1'b1;
        rf_if.iw_fl    = 4'hA;
        rf_if.iw_sr_read_addr1 = INDEX_FL;
        expect_val("fl_upd_byp", SEL_FL, 32'hA);
        expect_val("fl_upd_sr_byp", SEL_SR1, 32'hABCDEA);
        settle();
        idle();
        rf_if.iw_sr_read_addr2 = INDEX_FL;
        expect_val("fl_upd_fl", SEL_FL, 32'hA);
        expect_val("fl_upd_sr", SEL_SR2, 32'hABCDEA);
        settle();

        // Full SR write beats flag update
        idle();
        rf_if.iw_fl_we = 1'b1;
        rf_if.iw_fl    = 4'hF;
        sr_write(INDEX_FL, 24'h000000);
        rf_if.iw_sr_read_addr1 = INDEX_FL;
        expect_val("fl_prio_fl", SEL_FL, 32'h0);
        expect_val("fl_prio_sr", SEL_SR1, 32'h0);
        settle();
        idle();
        rf_if.iw_sr_read_addr1 = INDEX_FL;
        expect_val("fl_prio_fl_st", SEL_FL, 32'h0);
        expect_val("fl_prio_sr_st", SEL_SR1, 32'h0);
        settle();

        // Issue GP5 at N, hazard N+1..N+2, resolved by bypass at N+3
        idle();
        rf_if.iw_issue_gp_en   = 1'b1;
        rf_if.iw_issue_gp      = 4'd5;
        rf_if.iw_gp_read_addr1 = 4'd5;
        expect_val("gp5_issue_n", SEL_STALL, 32'h0);
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd5;
        expect_val("gp5_n1", SEL_STALL, 32'h1);
        settle();
        idle();
        rf_if.iw_gp_read_addr2 = 4'd5;
        expect_val("gp5_n2", SEL_STALL, 32'h1);
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd5;
        gp_write(4'd5, 24'h000555);
        expect_val("gp5_n3_stall", SEL_STALL, 32'h0);
        expect_val("gp5_n3_data", SEL_GP1, 32'h000555);
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd5;
        expect_val("gp5_n4", SEL_STALL, 32'h0);
        settle();

        // Issue and write GP7 together: bit stays set
        idle();
        rf_if.iw_issue_gp_en = 1'b1;
        rf_if.iw_issue_gp    = 4'd7;
        gp_write(4'd7, 24'h000777);
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd7;
        expect_val("gp7_set_wins", SEL_STALL, 32'h1);
        settle();
        idle();
        gp_write(4'd7, 24'h000778);
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd7;
        expect_val("gp7_cleared", SEL_STALL, 32'h0);
        settle();

        // Repeated issue does not count
        idle();
        rf_if.iw_issue_gp_en = 1'b1;
        rf_if.iw_issue_gp    = 4'd9;
        settle();
        idle();
        rf_if.iw_issue_gp_en = 1'b1;
        rf_if.iw_issue_gp    = 4'd9;
        settle();
        idle();
        gp_write(4'd9, 24'h000999);
        settle();
        idle();
        rf_if.iw_gp_read_addr2 = 4'd9;
        expect_val("gp9_no_count", SEL_STALL, 32'h0);
        settle();

        // SR hazards, and PC never becomes busy
        idle();
        rf_if.iw_issue_sr_en = 1'b1;
        rf_if.iw_issue_sr    = 4'd3;
        settle();
        idle();
        rf_if.iw_sr_read_addr2 = 4'd3;
        expect_val("sr3_busy", SEL_STALL, 32'h1);
        settle();
        idle();
        rf_if.iw_issue_sr_en = 1'b1;
        rf_if.iw_issue_sr    = INDEX_PC;
        sr_write(4'd3, 24'h000333);
        rf_if.iw_sr_read_addr2 = 4'd3;
        expect_val("sr3_bypass", SEL_STALL, 32'h0);
        settle();
        idle();
        rf_if.iw_sr_read_addr1 = INDEX_PC;
        rf_if.iw_sr_read_addr2 = 4'd3;
        expect_val("pc_never_busy", SEL_STALL, 32'h0);
        settle();

        // Reset mid-hazard, with a write and issue that must be discarded
        idle();
        gp_write(4'd1, 24'h000011);
        rf_if.iw_issue_gp_en = 1'b1;
        rf_if.iw_issue_gp    = 4'd2;
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd2;
        expect_val("pre_rst_stall", SEL_STALL, 32'h1);
        settle();
        idle();
        rst_n = 1'b0;
        gp_write(4'd6, 24'h000666);
        rf_if.iw_issue_gp_en = 1'b1;
        rf_if.iw_issue_gp    = 4'd8;
        settle();
        idle();
        rst_n = 1'b1;
        rf_if.iw_gp_read_addr1 = 4'd1;
        rf_if.iw_gp_read_addr2 = 4'd2;
        rf_if.iw_sr_read_addr1 = 4'd2;
        expect_val("post_rst_stall", SEL_STALL, 32'h0);
        expect_val("post_rst_gp1", SEL_GP1, 32'h0);
        expect_val("post_rst_gp2", SEL_GP2, 32'h0);
        expect_val("post_rst_sr2", SEL_SR1, 32'h0);
        settle();
        idle();
        rf_if.iw_gp_read_addr1 = 4'd6;
        rf_if.iw_gp_read_addr2 = 4'd8;
        expect_val("rst_wr_drop", SEL_GP1, 32'h0);
        expect_val("rst_issue_drop", SEL_STALL, 32'h0);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
